transaction_control: RTL and testbench

Responder for the main controller's transaction handshake. It waits for start_transaction, reads the player 1 balance, player 2 balance and stored key from balance memory, and validates the requested transfer. If valid, it writes the updated balances back, then runs the result animation through a start/done handshake. It returns finished_transaction so the main controller can advance to its reset-others phase.

---
 rtl/transaction_control_if.sv | 34 +++
 rtl/transaction_control.sv | 122 ++++++++++++
 tb/tb_transaction_control.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/transaction_control_if.sv
// Handshake and balance-memory bus between the main controller, the balance
// memory, the animation engine and the transaction responder.
interface transaction_control_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
);
  logic                  reset_others;
  logic                  start_transaction;
  logic [DATA_WIDTH-1:0] amount;
  logic [DATA_WIDTH-1:0] key;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  animation_done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  start_animation;
  logic [DATA_WIDTH-1:0] p1_balance;
  logic [DATA_WIDTH-1:0] p2_balance;
  logic                  transaction_ok;
  logic [1:0]            error_code;
  logic                  finished_transaction;

  modport slave (
    input  reset_others, start_transaction, amount, key, mem_rdata, animation_done,
    output mem_addr, mem_wren, mem_wdata, start_animation, p1_balance, p2_balance,
           transaction_ok, error_code, finished_transaction
  );

  modport master (
    output reset_others, start_transaction, amount, key, mem_rdata, animation_done,
    input  mem_addr, mem_wren, mem_wdata, start_animation, p1_balance, p2_balance,
           transaction_ok, error_code, finished_transaction
  );
endinterface

// File: rtl/transaction_control.sv
// Transaction responder: reads both balances and the stored key, validates the
// transfer, writes the new balances back and runs the result animation.
module transaction_control #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 2,
  parameter logic [ADDR_WIDTH-1:0] P1_ADDR    = ADDR_WIDTH'(0),
  parameter logic [ADDR_WIDTH-1:0] P2_ADDR    = ADDR_WIDTH'(1),
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR   = ADDR_WIDTH'(2)
) (
  input  logic                   clock,
  input  logic                   resetn,
  transaction_control_if.slave   bus
);

  typedef enum logic [3:0] {
    IDLE, RD_P1, RD_P2, RD_KEY, CHECK, WR_P1, WR_P2, ANIM, DONE
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] amount_q, key_q, p1_q, p2_q;
  logic                  ok_q;
  logic [1:0]            err_q;
  logic [1:0]            check_code;
  logic [DATA_WIDTH:0]   p2_sum;

  // The carry bit of this sum is the player 2 overflow flag.
  assign p2_sum = {1'b0, p2_q} + {1'b0, amount_q};

  always_comb begin
    if (bus.mem_rdata != key_q)  check_code = 2'b01;
    else if (amount_q > p1_q)    check_code = 2'b10;
    else if (p2_sum[DATA_WIDTH]) check_code = 2'b11;
    else                         check_code = 2'b00;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (!bus.reset_others) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_transaction) state_next = RD_P1;
        RD_P1:   state_next = RD_P2;
        RD_P2:   state_next = RD_KEY;
        RD_KEY:  state_next = CHECK;
        CHECK:   state_next = (check_code == 2'b00) ? WR_P1 : ANIM;
        WR_P1:   state_next = WR_P2;
        WR_P2:   state_next = ANIM;
        ANIM:    if (bus.animation_done) state_next = DONE;
        DONE:    if (!bus.start_transaction) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Strobes are gated by reset_others so a clear aborts a write in flight.
  always_comb begin
    bus.mem_addr             = P1_ADDR;
    bus.mem_wren             = 1'b0;
    bus.mem_wdata            = '0;
    bus.start_animation      = 1'b0;
    bus.finished_transaction = 1'b0;
    case (state)
      RD_P2:  bus.mem_addr = P2_ADDR;
      RD_KEY: bus.mem_addr = KEY_ADDR;
      WR_P1: begin
        bus.mem_wren  = bus.reset_others;
        bus.mem_wdata = p1_q - amount_q;
      end
      WR_P2: begin
        bus.mem_addr  = P2_ADDR;
        bus.mem_wren  = bus.reset_others;
        bus.mem_wdata = p2_sum[DATA_WIDTH-1:0];
      end
      ANIM:    bus.start_animation      = bus.reset_others;
      DONE:    bus.finished_transaction = bus.reset_others;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      amount_q <= '0;
      key_q    <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      ok_q     <= 1'b0;
      err_q    <= 2'b00;
    end else if (bus.reset_others) begin
      case (state)
        IDLE: if (bus.start_transaction) begin
          amount_q <= bus.amount;
          key_q    <= bus.key;
        end
        RD_P2:  p1_q <= bus.mem_rdata;
        RD_KEY: p2_q <= bus.mem_rdata;
        CHECK: begin
          err_q <= check_code;
          ok_q  <= (check_code == 2'b00);
        end
        WR_P1:   p1_q <= p1_q - amount_q;
        WR_P2:   p2_q <= p2_sum[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  assign bus.p1_balance     = p1_q;
  assign bus.p2_balance     = p2_q;
  assign bus.transaction_ok = ok_q;
  assign bus.error_code     = err_q;

endmodule

// File: tb/tb_transaction_control.sv
// Self-checking bench for transaction_control with a behavioural balance
// memory and a scoreboard of expected memory writes.
module tb_transaction_control;
  localparam int DW = 8;
  localparam int AW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  transaction_control_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  transaction_control #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .P1_ADDR(2'd0), .P2_ADDR(2'd1), .KEY_ADDR(2'd2)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  // Balance memory: registered read, write on mem_wren, bulk load from the bench.
  logic [DW-1:0] mem [4];
  logic          ld_en = 1'b0;
  logic [DW-1:0] ld_p1, ld_p2, ld_key;

  always @(posedge clock) begin
    if (ld_en) begin
      mem[0] <= ld_p1;
      mem[1] <= ld_p2;
      mem[2] <= ld_key;
      mem[3] <= 8'h00;
    end else if (bus.mem_wren) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Write scoreboard.
  wr_t exp_q[$];
  wr_t exp_wr;

  always @(negedge clock) begin
    if (resetn && bus.mem_wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0d, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        exp_wr = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== exp_wr) begin
          errors++;
          $display("FAIL write: addr=%0d data=%0d, required addr=%0d data=%0d",
                   bus.mem_addr, bus.mem_wdata, exp_wr.addr, exp_wr.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  logic [1:0]    exp_err;
  logic          exp_ok;
  logic [DW-1:0] exp_p1, exp_p2;

  function automatic logic [1:0] model_err(input logic [DW-1:0] p1, p2, kmem, amt, k);
    if (k != kmem)                   return 2'b01;
    if (amt > p1)                    return 2'b10;
    if (int'(p2) + int'(amt) > 255)  return 2'b11;
    return 2'b00;
  endfunction

  task automatic load_mem(input logic [DW-1:0] p1, p2, kmem);
    @(negedge clock);
    ld_p1 = p1; ld_p2 = p2; ld_key = kmem; ld_en = 1'b1;
    @(negedge clock);
    ld_en = 1'b0;
  endtask

  // Loads memory, records expectations, raises start on a falling edge.
  task automatic start_txn(input logic [DW-1:0] p1, p2, kmem, amt, k, input bit push);
    load_mem(p1, p2, kmem);
    exp_err = model_err(p1, p2, kmem, amt, k);
    exp_ok  = (exp_err == 2'b00);
    exp_p1  = exp_ok ? p1 - amt : p1;
    exp_p2  = exp_ok ? p2 + amt : p2;
    if (exp_ok && push) begin
      exp_q.push_back('{addr: 2'd0, data: p1 - amt});
      exp_q.push_back('{addr: 2'd1, data: p2 + amt});
    end
    bus.amount = amt;
    bus.key    = k;
    bus.start_transaction = 1'b1;
  endtask

  task automatic check_results(input string name);
    checks++;
    if (bus.error_code !== exp_err) begin
      errors++;
      $display("FAIL %s error_code: got %b, required %b", name, bus.error_code, exp_err);
    end
    checks++;
    if (bus.transaction_ok !== exp_ok) begin
      errors++;
      $display("FAIL %s transaction_ok: got %b, required %b", name, bus.transaction_ok, exp_ok);
    end
    checks++;
    if ({bus.p1_balance, bus.p2_balance} !== {exp_p1, exp_p2}) begin
      errors++;
      $display("FAIL %s balances: got p1=%0d p2=%0d, required p1=%0d p2=%0d",
               name, bus.p1_balance, bus.p2_balance, exp_p1, exp_p2);
    end
    checks++;
    if ({mem[0], mem[1]} !== {exp_p1, exp_p2}) begin
      errors++;
      $display("FAIL %s memory: got p1=%0d p2=%0d, required p1=%0d p2=%0d",
               name, mem[0], mem[1], exp_p1, exp_p2);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending_writes: got %0d outstanding, required 0", name, exp_q.size());
    end
  endtask

  // Full transaction with animation_done high; amount/key are scrambled after sampling.
  task automatic run_txn(input string name, input logic [DW-1:0] p1, p2, kmem, amt, k);
    int cycles = 0;
    bit seen   = 1'b0;
    start_txn(p1, p2, kmem, amt, k, 1'b1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      cycles++;
      if (cycles == 1) begin
        bus.amount = 8'($urandom);
        bus.key    = 8'($urandom);
      end
      if (bus.finished_transaction) seen = 1'b1;
    end
    checks++;
    if (!seen || cycles != (exp_ok ? 8 : 6)) begin
      errors++;
      $display("FAIL %s latency: got %0d clocks (seen=%0b), required %0d",
               name, cycles, seen, exp_ok ? 8 : 6);
    end
    check_results(name);
    @(negedge clock);
    checks++;
    if (bus.finished_transaction !== 1'b1) begin
      errors++;
      $display("FAIL %s finished_hold: got %b, required 1", name, bus.finished_transaction);
    end
    bus.start_transaction = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.finished_transaction !== 1'b0) begin
      errors++;
      $display("FAIL %s finished_release: got %b, required 0", name, bus.finished_transaction);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.mem_addr, bus.mem_wren, bus.mem_wdata, bus.start_animation, bus.p1_balance,
         bus.p2_balance, bus.transaction_ok, bus.error_code, bus.finished_transaction} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got addr=%0d wren=%b wdata=%0d anim=%b p1=%0d p2=%0d ok=%b err=%b fin=%b, required all 0",
               name, bus.mem_addr, bus.mem_wren, bus.mem_wdata, bus.start_animation, bus.p1_balance,
               bus.p2_balance, bus.transaction_ok, bus.error_code, bus.finished_transaction);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_commit();
    run_txn("commit", 8'd100, 8'd50, 8'h5A, 8'd30, 8'h5A);
  endtask

  task automatic test_bad_key();
    run_txn("bad_key", 8'd100, 8'd50, 8'h5A, 8'd30, 8'h5B);
  endtask

  task automatic test_funds();
    run_txn("funds_short", 8'd20, 8'd50, 8'h5A, 8'd21, 8'h5A);
    run_txn("funds_exact", 8'd20, 8'd50, 8'h5A, 8'd20, 8'h5A);
  endtask

  task automatic test_overflow();
    run_txn("p2_overflow", 8'd100, 8'd250, 8'h5A, 8'd6, 8'h5A);
    run_txn("p2_max", 8'd100, 8'd250, 8'h5A, 8'd5, 8'h5A);
  endtask

  task automatic test_amount_zero();
    run_txn("amount_zero", 8'd100, 8'd50, 8'hC3, 8'd0, 8'hC3);
  endtask

  task automatic test_start_drop();
    int  cycles = 3;
    bit  seen   = 1'b0;
    start_txn(8'd100, 8'd50, 8'h5A, 8'd10, 8'h5A, 1'b1);
    repeat (3) @(negedge clock);
    bus.start_transaction = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      cycles++;
      if (bus.finished_transaction) seen = 1'b1;
    end
    checks++;
    if (!seen || cycles != 8) begin
      errors++;
      $display("FAIL start_drop latency: got %0d clocks (seen=%0b), required 8", cycles, seen);
    end
    check_results("start_drop");
    @(negedge clock);
    checks++;
    if ({bus.finished_transaction, bus.start_animation} !== 2'b00) begin
      errors++;
      $display("FAIL start_drop release: got fin=%b anim=%b, required 0 0",
               bus.finished_transaction, bus.start_animation);
    end
  endtask

  task automatic test_anim_stall();
    bit bad = 1'b0;
    bus.animation_done = 1'b0;
    start_txn(8'd100, 8'd50, 8'h5A, 8'd1, 8'h5A, 1'b1);
    repeat (7) @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.start_animation !== 1'b1 || bus.finished_transaction !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL anim_stall: got anim=%b fin=%b during stall, required anim=1 fin=0",
               bus.start_animation, bus.finished_transaction);
    end
    bus.animation_done = 1'b1;
    @(negedge clock);
    checks++;
    if ({bus.finished_transaction, bus.start_animation} !== 2'b10) begin
      errors++;
      $display("FAIL anim_done: got fin=%b anim=%b, required fin=1 anim=0",
               bus.finished_transaction, bus.start_animation);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.finished_transaction !== 1'b1) begin
      errors++;
      $display("FAIL anim_hold: got fin=%b, required 1", bus.finished_transaction);
    end
    check_results("anim_stall");
    bus.start_transaction = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.finished_transaction !== 1'b0) begin
      errors++;
      $display("FAIL anim_release: got fin=%b, required 0", bus.finished_transaction);
    end
  endtask

  task automatic test_reset_others();
    start_txn(8'd100, 8'd50, 8'h5A, 8'd30, 8'h5A, 1'b0);
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if ({bus.mem_wren, bus.mem_addr} !== {1'b1, 2'd0}) begin
      errors++;
      $display("FAIL rst_others wr_p1: got wren=%b addr=%0d, required wren=1 addr=0",
               bus.mem_wren, bus.mem_addr);
    end
    bus.reset_others = 1'b0;
    #1;
    checks++;
    if (bus.mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL rst_others wren: got %b, required 0", bus.mem_wren);
    end
    @(posedge clock);
    #1;
    exp_err = 2'b00; exp_ok = 1'b1; exp_p1 = 8'd100; exp_p2 = 8'd50;
    check_results("rst_others");
    bus.start_transaction = 1'b0;
    @(negedge clock);
    bus.reset_others = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_resetn_anim();
    bus.animation_done = 1'b0;
    start_txn(8'd100, 8'd50, 8'h5A, 8'd30, 8'h5A, 1'b1);
    repeat (7) @(negedge clock);
    checks++;
    if (bus.start_animation !== 1'b1) begin
      errors++;
      $display("FAIL resetn_anim entry: got anim=%b, required 1", bus.start_animation);
    end
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("resetn_anim");
    bus.animation_done    = 1'b1;
    bus.start_transaction = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    bus.reset_others      = 1'b1;
    bus.start_transaction = 1'b0;
    bus.amount            = '0;
    bus.key               = '0;
    bus.animation_done    = 1'b1;
    ld_p1 = '0; ld_p2 = '0; ld_key = '0;

    test_reset();
    test_commit();
    test_bad_key();
    test_funds();
    test_overflow();
    test_amount_zero();
    test_start_drop();
    test_anim_stall();
    test_reset_others();
    test_resetn_anim();
    run_txn("after_reset", 8'd200, 8'd10, 8'h11, 8'd55, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
